// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared defaults and channel-index width helper for arb_mux
package arb_mux_pkg;

  localparam int N_CH_DEFAULT  = 4;
  localparam int WIDTH_DEFAULT = 8;

  // A single-channel build still needs a 1-bit index so ports never collapse to zero width.
  function automatic int chan_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// rtl/arb_mux_rr_pick.sv - combinational round-robin picker
// Searches ptr+1, ptr+2, ... modulo N_CH and returns the first requester.
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter int N_CH = N_CH_DEFAULT,
  parameter int CW   = chan_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   ptr,
  output logic [N_CH-1:0] grant,
  output logic [CW-1:0]   idx,
  output logic            any
);

  logic [CW-1:0] cand;

  // k runs to N_CH so the last-granted channel itself is considered last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = CW'((int'(ptr) + k) % N_CH);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - round-robin N:1 stream arbiter with a registered output stage
// Holds one output word; a drain and a new grant may share a cycle for full throughput.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int N_CH  = N_CH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CW    = chan_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CW-1:0]         out_chan,
  input  logic                  out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [CW-1:0]    out_chan_q,  out_chan_d;
  logic [CW-1:0]    ptr_q,       ptr_d;

  logic             load_en;
  logic [N_CH-1:0]  pick_grant;
  logic [CW-1:0]    pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] sel_data;

  rr_pick #(
    .N_CH (N_CH),
    .CW   (CW)
  ) u_pick (
    .req   (in_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // One-hot AND-OR select avoids a variable part-select on the wide data bus.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (pick_grant[i]) begin
        sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    load_en     = !out_valid_q || out_ready;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    // Gated by rst so nothing is acknowledged that the reset edge will then drop.
    in_ready    = (load_en && !rst) ? pick_grant : '0;
    if (load_en) begin
      if (pick_any) begin
        out_valid_d = 1'b1;
        out_data_d  = sel_data;
        out_chan_d  = pick_idx;
        ptr_d       = pick_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= CW'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - directed vector table plus a backpressured round-robin sequence for arb_mux
module tb_arb_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arb_mux #(
    .N_CH  (4),
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_oc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic [3:0] v, input logic [31:0] d,
                         input logic o, input logic [3:0] er, input logic eov,
                         input logic [7:0] eod, input logic [1:0] eoc);
    vec_t t;
    t.rst = r; t.vld = v; t.data = d; t.ordy = o;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_oc = eoc;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    int         last;
    logic       ov_m;
    logic       blocked;
    logic [3:0] exp_r;

    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;

    // rst v    data          ordy in_rdy  ov  od     oc
    add_vec(1, 4'hF, 32'h44332211, 1, 4'b0000, 0, 8'h00, 0);  // 0  reset, all requesting
    add_vec(1, 4'hF, 32'h44332211, 1, 4'b0000, 0, 8'h00, 0);  // 1
    add_vec(0, 4'h4, 32'h00A50000, 1, 4'b0100, 1, 8'hA5, 2);  // 2  single channel 2
    add_vec(0, 4'h0, 32'h00000000, 1, 4'b0000, 0, 8'hA5, 2);  // 3  idle drain
    add_vec(1, 4'h0, 32'h00000000, 1, 4'b0000, 0, 8'h00, 0);  // 4  reset again
    for (int i = 0; i < 8; i++) begin                        // 5-12 full load
      add_vec(0, 4'hF, 32'h44332211, 1, 4'(1 << (i % 4)), 1,
              8'((i % 4 + 1) * 8'h11), 2'(i % 4));
    end
    add_vec(0, 4'h1, 32'h0000003C, 1, 4'b0001, 1, 8'h3C, 0);  // 13 load 0x3C
    add_vec(0, 4'hF, 32'h44332211, 0, 4'b0000, 1, 8'h3C, 0);  // 14 backpressure
    add_vec(0, 4'hF, 32'h44332211, 0, 4'b0000, 1, 8'h3C, 0);  // 15
    add_vec(0, 4'hF, 32'h44332211, 0, 4'b0000, 1, 8'h3C, 0);  // 16
    add_vec(0, 4'hF, 32'h44332211, 1, 4'b0010, 1, 8'h22, 1);  // 17 release
    add_vec(0, 4'h9, 32'h99000088, 1, 4'b1000, 1, 8'h99, 3);  // 18 skip: ptr=1 -> 3
    add_vec(0, 4'h9, 32'h99000088, 1, 4'b0001, 1, 8'h88, 0);  // 19 then 0
    add_vec(0, 4'h4, 32'h005A0000, 1, 4'b0100, 1, 8'h5A, 2);  // 20 ptr=2, out_valid=1
    add_vec(1, 4'hF, 32'h44332211, 1, 4'b0000, 0, 8'h00, 0);  // 21 mid-op reset
    add_vec(0, 4'hF, 32'h44332211, 1, 4'b0001, 1, 8'h11, 0);  // 22 restart at channel 0
    add_vec(0, 4'h2, 32'h00007700, 1, 4'b0010, 1, 8'h77, 1);  // 23 lone requester
    add_vec(0, 4'h2, 32'h00007700, 1, 4'b0010, 1, 8'h77, 1);  // 24
    add_vec(0, 4'h2, 32'h00007700, 1, 4'b0010, 1, 8'h77, 1);  // 25
    add_vec(0, 4'h0, 32'h00000000, 0, 4'b0000, 1, 8'h77, 1);  // 26 hold, no requests

    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; in_valid = vecs[i].vld;
      in_data = vecs[i].data; out_ready = vecs[i].ordy;
      #3;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
      check($sformatf("v%0d out_chan", i), 32'(out_chan), 32'(vecs[i].exp_oc));
    end

    // Full load under intermittent backpressure: grants must rotate strictly.
    last = 1;
    ov_m = 1'b1;
    for (int c = 0; c < 40; c++) begin
      rst = 1'b0; in_valid = 4'hF; in_data = 32'h44332211;
      out_ready = (c % 3 != 2);
      #3;
      blocked = ov_m && !out_ready;
      exp_r   = blocked ? 4'b0000 : 4'(1 << ((last + 1) % 4));
      check($sformatf("seq%0d in_ready", c), 32'(in_ready), 32'(exp_r));
      @(posedge clk); #1;
      if (!blocked) begin
        last = (last + 1) % 4;
        ov_m = 1'b1;
      end
      check($sformatf("seq%0d out_valid", c), 32'(out_valid), 32'(ov_m));
      check($sformatf("seq%0d out_chan", c), 32'(out_chan), 32'(last));
      check($sformatf("seq%0d out_data", c), 32'(out_data), 32'((last + 1) * 8'h11));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001: Parameter N_CH, default 4, SHALL set the number of input channels (legal range 2..16).
REQ-002: Parameter WIDTH, default 8, SHALL set the data width of each channel (legal range 1..64).
REQ-003: Parameter CW, default $clog2(N_CH), SHALL set the width of the channel-index output and is not overridden by users.
REQ-004: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005: rst  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-006: in_valid  input  N_CH  SHALL carry one per-channel request bit.
REQ-007: in_data  input  N_CH*WIDTH  SHALL carry channel i data in bits [i*WIDTH +: WIDTH].
REQ-008: in_ready  output  N_CH  SHALL signal that channel i's word is accepted this cycle.
REQ-009: out_valid  output  1  SHALL mark that the output register holds a word.
REQ-010: out_data  output  WIDTH  SHALL carry the registered selected word.
REQ-011: out_chan  output  CW  SHALL carry the index of the channel that supplied out_data.
REQ-012: out_ready  input  1  SHALL be the downstream acceptance signal.

Function
REQ-013: A transfer on any port SHALL occur only in a cycle where both valid and ready are high on that port.
REQ-014: load_en SHALL be (!out_valid || out_ready) and SHALL be computed combinationally.
REQ-015: The winner SHALL be the first channel with in_valid high, searching indices ptr+1, ptr+2, ... modulo N_CH, where ptr is the last granted index.
REQ-016: in_ready[i] SHALL be high only when load_en is high, any in_valid is high, and i is the winner; it SHALL be one-hot or zero.
REQ-017: On a grant, the next edge SHALL set out_data to the winner's word, out_chan to the winner index, out_valid to 1, and ptr to the winner index.
REQ-018: When load_en is high and no channel requests, the next edge SHALL clear out_valid and leave out_data, out_chan and ptr unchanged.
REQ-019: While out_valid && !out_ready, out_data, out_chan, out_valid and ptr SHALL hold, and all in_ready SHALL be 0.
REQ-020: Latency from input acceptance to out_valid SHALL be exactly 1 cycle, and sustained throughput SHALL be 1 word per cycle with out_ready held high.
REQ-021: A simultaneous drain and grant in the same cycle SHALL replace the output word with no bubble.
REQ-022: A single channel requesting continuously with no competitors SHALL be granted every cycle.
REQ-023: Under full load, every requesting channel SHALL be granted within N_CH grants (starvation-free).
REQ-024: in_valid dropping without a handshake SHALL NOT be treated as an error; the block SHALL make no assumption about input stability.

Reset
REQ-025: While rst is high, out_valid SHALL be 0, out_data SHALL be 0, out_chan SHALL be 0, ptr SHALL be N_CH-1, and in_ready SHALL be all 0.
REQ-026: Reset asserted mid-transfer SHALL discard the held word; the first grant after reset SHALL search from channel 0.

Structure
REQ-027: Package arb_mux_pkg SHALL hold the default N_CH and WIDTH constants and the channel-index width function.
REQ-028: The round-robin search SHALL be a combinational sub-module rr_pick (inputs: req, ptr; outputs: grant one-hot, idx, any).
REQ-029: arb_mux SHALL contain only the output register, ptr register and handshake logic; there SHALL be no other state.

Verification (N_CH=4, WIDTH=8)
REQ-030: Reset check: hold rst for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0x00, out_chan=0, in_ready=0000.
REQ-031: Single channel: after reset, in_valid=0100, data2=0xA5, out_ready=1 -> in_ready=0100 in that cycle; next cycle out_valid=1, out_data=0xA5, out_chan=2.
REQ-032: Full load: in_valid=1111 for 8 cycles, out_ready=1 -> out_chan sequence 0,1,2,3,0,1,2,3 with no bubble.
REQ-033: Backpressure: hold out_ready=0 for 3 cycles while out_valid=1, out_data=0x3C -> output stable, in_ready=0000; on out_ready=1 a new grant loads the next cycle.
REQ-034: Skip: ptr=1, in_valid=1001 -> channel 3 granted first, then channel 0.
REQ-035: Mid-operation reset: assert rst while out_valid=1 and ptr=2 -> out_valid=0 the next cycle, and the following full-load grant goes to channel 0.
